// File: rtl/merge_arb_pkg.sv
// Shared types and helpers for the 3-input NoC merge arbiter.
// Holds the FSM state encoding and the rotating-priority pick function.
package merge_arb_pkg;

  localparam int NUM_IN      = 3;
  localparam int SEL_W       = 2;
  localparam int TIMEOUT_DEF = 255;
  localparam int TO_W_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Scan ptr+1, ptr+2, ptr (mod NUM_IN); the input just served ranks last.
  function automatic pick_t next_rr(input logic [SEL_W-1:0] ptr,
                                    input logic [NUM_IN-1:0] req);
    pick_t p;
    p = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      int c;
      c = (int'(ptr) + k) % NUM_IN;
      if (!p.found && req[c]) begin
        p.found = 1'b1;
        p.idx   = SEL_W'(c);
      end
    end
    return p;
  endfunction

  function automatic logic [NUM_IN-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_IN'(1) << idx;
  endfunction

endpackage

// File: rtl/merge_arbiter_rr_pick.sv
// Combinational 3-way rotating priority encoder.
// Shared with the other NoC arbiters; the lowest priority is the last winner.
module rr_pick
  import merge_arb_pkg::*;
(
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  rr_ptr,
  output logic [SEL_W-1:0]  winner,
  output logic              found
);

  pick_t pick;

  always_comb begin
    pick   = next_rr(rr_ptr, req);
    winner = pick.idx;
    found  = pick.found;
  end

endmodule

// File: rtl/merge_arbiter.sv
// Select-token scheduler for the 3-input NoC merge: round-robin grant,
// packet lock held until the tail flit, forced release after an idle timeout.
module merge_arbiter
  import merge_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] req,
  input  logic [NUM_IN-1:0] tail,
  output logic [SEL_W-1:0]  sel,
  output logic              sel_valid,
  input  logic              sel_ready,
  input  logic              flit_sent,
  output logic              lock_active,
  output logic [SEL_W-1:0]  owner,
  output logic              timeout_err,
  output logic              proto_err
);

  state_t            st_q, st_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              valid_q, valid_d;
  logic              lock_q, lock_d;
  logic [SEL_W-1:0]  owner_q, owner_d;
  logic [SEL_W-1:0]  rr_q, rr_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [TO_W-1:0]   cnt_inc;
  logic              is_tail_q, is_tail_d;
  logic              to_err_q, to_err_d;
  logic              pe_q, pe_d;
  logic [SEL_W-1:0]  winner;
  logic              found;

  rr_pick u_rr_pick (
    .req    (req),
    .rr_ptr (rr_q),
    .winner (winner),
    .found  (found)
  );

  assign cnt_inc = cnt_q + 1'b1;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    st_d      = st_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    lock_d    = lock_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    is_tail_d = is_tail_q;
    to_err_d  = 1'b0;
    pe_d      = 1'b0;
    unique case (st_q)
      IDLE: begin
        pe_d = flit_sent;
        if (lock_q) begin
          if (|(req & onehot(owner_q))) begin
            sel_d   = owner_q;
            valid_d = 1'b1;
            st_d    = ISSUE;
            cnt_d   = '0;
          end else if (cnt_inc == TO_W'(TIMEOUT)) begin
            // Stalled owner: hand priority on as if its packet had completed.
            lock_d   = 1'b0;
            owner_d  = '0;
            rr_d     = owner_q;
            to_err_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (found) begin
          sel_d   = winner;
          valid_d = 1'b1;
          st_d    = ISSUE;
          cnt_d   = '0;
        end
      end
      ISSUE: begin
        pe_d = flit_sent;
        if (sel_ready) begin
          is_tail_d = |(tail & onehot(sel_q));
          valid_d   = 1'b0;
          st_d      = WAIT;
        end
      end
      WAIT: begin
        if (flit_sent) begin
          st_d = IDLE;
          if (is_tail_q) begin
            lock_d  = 1'b0;
            owner_d = '0;
            rr_d    = sel_q;
          end else begin
            lock_d  = 1'b1;
            owner_d = sel_q;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q      <= IDLE;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      lock_q    <= 1'b0;
      owner_q   <= '0;
      rr_q      <= SEL_W'(NUM_IN - 1);
      cnt_q     <= '0;
      is_tail_q <= 1'b0;
      to_err_q  <= 1'b0;
      pe_q      <= 1'b0;
    end else begin
      st_q      <= st_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      lock_q    <= lock_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      is_tail_q <= is_tail_d;
      to_err_q  <= to_err_d;
      pe_q      <= pe_d;
    end
  end

  assign sel         = sel_q;
  assign sel_valid   = valid_q;
  assign lock_active = lock_q;
  assign owner       = owner_q;
  assign timeout_err = to_err_q;
  assign proto_err   = pe_q;

  a_sel_legal: assert property (@(posedge clk) disable iff (reset)
    sel_valid |-> (sel < SEL_W'(NUM_IN)));

endmodule

// File: tb/tb_merge_arbiter.sv
// Self-checking bench for merge_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a cycle-level reference model.
module tb_merge_arbiter;

  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req, tail;
  logic [1:0] sel, owner;
  logic       sel_valid, sel_ready, flit_sent;
  logic       lock_active, timeout_err, proto_err;

  int n_cmp = 0;
  int n_bad = 0;

  merge_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .tail        (tail),
    .sel         (sel),
    .sel_valid   (sel_valid),
    .sel_ready   (sel_ready),
    .flit_sent   (flit_sent),
    .lock_active (lock_active),
    .owner       (owner),
    .timeout_err (timeout_err),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0=waiting for a decision, 1=token offered, 2=flit in flight.
  int m_phase, m_sel, m_owner, m_last, m_idle;
  bit m_valid, m_lock, m_tail, m_to, m_pe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_sel = 0; m_owner = 0; m_last = 2; m_idle = 0;
    m_valid = 0; m_lock = 0; m_tail = 0; m_to = 0; m_pe = 0;
  endtask

  // Advance the model by one clock given the inputs applied during that cycle.
  task automatic model_step(input logic [2:0] r, t, input logic rdy, fs);
    int ph, sl, ow, ls, idl;
    bit vl, lk, tl;
    ph = m_phase; sl = m_sel; ow = m_owner; ls = m_last; idl = m_idle;
    vl = m_valid; lk = m_lock; tl = m_tail;
    m_to = 0; m_pe = 0;
    if (m_phase == 0) begin
      m_pe = fs;
      if (m_lock) begin
        if (r[m_owner]) begin
          sl = m_owner; vl = 1; ph = 1; idl = 0;
        end else if (m_idle + 1 >= TIMEOUT) begin
          lk = 0; ls = m_owner; ow = 0; m_to = 1; idl = 0;
        end else begin
          idl = m_idle + 1;
        end
      end else begin
        for (int k = 1; k <= 3; k++) begin
          int c;
          c = (m_last + k) % 3;
          if (ph == 0 && r[c]) begin
            sl = c; vl = 1; ph = 1;
          end
        end
      end
    end else if (m_phase == 1) begin
      m_pe = fs;
      if (rdy) begin
        tl = t[m_sel]; vl = 0; ph = 2;
      end
    end else if (fs) begin
      ph = 0;
      if (m_tail) begin
        lk = 0; ow = 0; ls = m_sel;
      end else begin
        lk = 1; ow = m_sel;
      end
    end
    m_phase = ph; m_sel = sl; m_owner = ow; m_last = ls; m_idle = idl;
    m_valid = vl; m_lock = lk; m_tail = tl;
  endtask

  task automatic step(input logic [2:0] r, t, input logic rdy, fs);
    req = r; tail = t; sel_ready = rdy; flit_sent = fs;
    model_step(r, t, rdy, fs);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req = '0; tail = '0; sel_ready = 0; flit_sent = 0;
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  task automatic check_model(input string tag);
    check({tag, ".sel_valid"},   32'(sel_valid),   32'(m_valid));
    check({tag, ".sel"},         32'(sel),         32'(m_sel));
    check({tag, ".lock_active"}, 32'(lock_active), 32'(m_lock));
    check({tag, ".owner"},       32'(owner),       32'(m_owner));
    check({tag, ".timeout_err"}, 32'(timeout_err), 32'(m_to));
    check({tag, ".proto_err"},   32'(proto_err),   32'(m_pe));
  endtask

  typedef struct {
    bit         rst_first;
    logic [2:0] req;
    logic [2:0] tail;
    logic       rdy;
    logic       fs;
    logic       e_valid;
    logic [1:0] e_sel;
    logic       e_lock;
    logic [1:0] e_owner;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Round-robin with single-flit packets: 0,1,2,0 and never a lock.
    vecs.push_back('{1'b1, 3'b111, 3'b111, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b111, 3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b111, 3'b111, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b111, 3'b111, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b111, 3'b111, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b111, 3'b111, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b111, 3'b111, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b111, 3'b111, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b111, 3'b111, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b111, 3'b111, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0});
    // Input 0 sends a 3-flit packet while input 1 keeps requesting.
    vecs.push_back('{1'b1, 3'b011, 3'b010, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b011, 3'b010, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b011, 3'b010, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0});
    vecs.push_back('{1'b0, 3'b011, 3'b010, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0});
    vecs.push_back('{1'b0, 3'b011, 3'b010, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0});
    vecs.push_back('{1'b0, 3'b011, 3'b010, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0});
    vecs.push_back('{1'b0, 3'b011, 3'b011, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0});
    vecs.push_back('{1'b0, 3'b011, 3'b011, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0});
    vecs.push_back('{1'b0, 3'b011, 3'b011, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b011, 3'b011, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0});

    reset = 1;
    req = '0; tail = '0; sel_ready = 0; flit_sent = 0;
    model_reset();
    @(negedge clk);
    check("rst.sel_valid",   32'(sel_valid),   0);
    check("rst.sel",         32'(sel),         0);
    check("rst.lock_active", 32'(lock_active), 0);
    check("rst.owner",       32'(owner),       0);
    check("rst.timeout_err", 32'(timeout_err), 0);
    check("rst.proto_err",   32'(proto_err),   0);
    @(negedge clk);
    reset = 0;

    foreach (vecs[i]) begin
      if (vecs[i].rst_first) do_reset();
      step(vecs[i].req, vecs[i].tail, vecs[i].rdy, vecs[i].fs);
      check($sformatf("vec%0d.sel_valid", i), 32'(sel_valid),   32'(vecs[i].e_valid));
      check($sformatf("vec%0d.sel", i),       32'(sel),         32'(vecs[i].e_sel));
      check($sformatf("vec%0d.lock", i),      32'(lock_active), 32'(vecs[i].e_lock));
      check($sformatf("vec%0d.owner", i),     32'(owner),       32'(vecs[i].e_owner));
    end

    // Token held in ISSUE while sel_ready stays low and requests toggle.
    do_reset();
    step(3'b111, 3'b111, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(3'($urandom), 3'($urandom), 1'b0, 1'b0);
      check("stall.sel_valid", 32'(sel_valid), 1);
      check("stall.sel",       32'(sel),       0);
    end
    step(3'b111, 3'b111, 1'b1, 1'b0);
    check("stall.accept", 32'(sel_valid), 0);

    // Lock on input 2, owner goes silent, input 0 waits for the timeout.
    do_reset();
    step(3'b100, 3'b000, 1'b1, 1'b0);
    check("to.first_sel", 32'(sel), 2);
    step(3'b100, 3'b000, 1'b1, 1'b0);
    step(3'b000, 3'b000, 1'b1, 1'b1);
    check("to.lock",  32'(lock_active), 1);
    check("to.owner", 32'(owner),       2);
    for (int i = 1; i < TIMEOUT; i++) begin
      step(3'b001, 3'b001, 1'b1, 1'b0);
      check("to.early_err",  32'(timeout_err), 0);
      check("to.held_lock",  32'(lock_active), 1);
      check("to.no_serve",   32'(sel_valid),   0);
    end
    step(3'b001, 3'b001, 1'b1, 1'b0);
    check("to.err_pulse", 32'(timeout_err), 1);
    check("to.released",  32'(lock_active), 0);
    check("to.owner0",    32'(owner),       0);
    step(3'b001, 3'b001, 1'b1, 1'b0);
    check("to.err_single", 32'(timeout_err), 0);
    check("to.served_v",   32'(sel_valid),   1);
    check("to.served_sel", 32'(sel),         0);

    // Stray flit_sent in IDLE.
    do_reset();
    step(3'b000, 3'b000, 1'b0, 1'b1);
    check("pe.pulse", 32'(proto_err), 1);
    check("pe.valid", 32'(sel_valid), 0);
    for (int i = 0; i < 3; i++) begin
      step(3'b000, 3'b000, 1'b1, 1'b0);
      check("pe.cleared",  32'(proto_err), 0);
      check("pe.no_token", 32'(sel_valid), 0);
    end

    // Asynchronous reset in WAIT while a lock is held.
    do_reset();
    step(3'b001, 3'b000, 1'b1, 1'b0);
    step(3'b001, 3'b000, 1'b1, 1'b0);
    step(3'b001, 3'b000, 1'b1, 1'b1);
    step(3'b001, 3'b000, 1'b1, 1'b0);
    step(3'b001, 3'b000, 1'b1, 1'b0);
    check("ar.locked", 32'(lock_active), 1);
    #2 reset = 1;
    #1;
    check("ar.sel_valid", 32'(sel_valid),   0);
    check("ar.lock",      32'(lock_active), 0);
    check("ar.owner",     32'(owner),       0);
    @(negedge clk);
    reset = 0;
    model_reset();
    step(3'b111, 3'b111, 1'b1, 1'b0);
    check("ar.first_sel", 32'(sel),       0);
    check("ar.first_v",   32'(sel_valid), 1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic fs;
      fs = (m_phase == 2) ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
      step(3'($urandom), 3'($urandom), 1'($urandom), fs);
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
